// File: rtl/cache_tag_ctrl.sv
// Sequencing controller for a 2-way set-associative cache tag store: init sweep, lookup, LRU victim, refill.
// Optional flush port enabled by defining CACHE_TAG_FLUSH_EN.
module cache_tag_ctrl #(
    parameter int unsigned IDX_W = 7,
    parameter int unsigned OFF_W = 5,
    parameter int unsigned TAG_W = 20,
    localparam int unsigned ADDR_W = TAG_W + IDX_W + OFF_W,
    localparam int unsigned ENT_W = TAG_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CACHE_TAG_FLUSH_EN
    input  logic                 flush_req,
`endif
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic                 resp_way,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_done,
    output logic [IDX_W-1:0]     tag_raddr,
    input  logic [2*ENT_W-1:0]   tag_rdata,
    output logic [IDX_W-1:0]     tag_waddr,
    output logic [1:0]           tag_we,
    output logic [ENT_W-1:0]     tag_wdata,
    output logic                 busy
);

    localparam int unsigned SETS = 1 << IDX_W;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;

    localparam logic [2:0] S_INIT        = 3'd0;
    localparam logic [2:0] S_IDLE        = 3'd1;
    localparam logic [2:0] S_LOOKUP      = 3'd2;
    localparam logic [2:0] S_MISS_REQ    = 3'd3;
    localparam logic [2:0] S_REFILL_WAIT = 3'd4;
    localparam logic [2:0] S_WRITE_TAG   = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [IDX_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q;
    logic              victim;
    logic [SETS-1:0]   lru;
    logic              flush;
    logic              unused_off;

    logic [IDX_W-1:0]  set_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  tag0;
    logic [TAG_W-1:0]  tag1;
    logic              v0;
    logic              v1;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              miss_victim;

`ifdef CACHE_TAG_FLUSH_EN
    assign flush = flush_req;
`else
    assign flush = 1'b0;
`endif

    // Offset bits never reach the tag path; refills are line-aligned.
    assign unused_off = ^req_addr[OFF_W-1:0];

    assign set_q = line_q[IDX_W-1:0];
    assign tag_q = line_q[LINE_W-1:IDX_W];
    assign tag0  = tag_rdata[TAG_W-1:0];
    assign v0    = tag_rdata[TAG_W];
    assign tag1  = tag_rdata[ENT_W+TAG_W-1:ENT_W];
    assign v1    = tag_rdata[2*ENT_W-1];

    // Way 0 wins if both ways claim the tag.
    assign hit0        = v0 && (tag0 == tag_q);
    assign hit1        = v1 && (tag1 == tag_q);
    assign hit         = hit0 || hit1;
    assign hit_way     = !hit0;
    assign miss_victim = v0 ? (v1 ? lru[set_q] : 1'b1) : 1'b0;

    assign mem_addr  = {line_q, OFF_W'(0)};
    assign tag_raddr = (state == S_IDLE) ? req_addr[OFF_W +: IDX_W] : set_q;
    assign tag_waddr = (state == S_INIT) ? cnt : set_q;
    assign tag_wdata = (state == S_INIT) ? ENT_W'(0) : {1'b1, tag_q};

    // Write enables are suppressed while reset is held so the sweep starts cleanly.
    always_comb begin
        tag_we = 2'b00;
        if (state == S_INIT && !rst)
            tag_we = 2'b11;
        else if (state == S_WRITE_TAG)
            tag_we = victim ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_INIT;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_INIT:        if (cnt == IDX_W'(SETS - 1)) state_n = S_IDLE;
            S_IDLE: begin
                if (flush)
                    state_n = S_INIT;
                else if (req_valid)
                    state_n = S_LOOKUP;
            end
            S_LOOKUP:      state_n = hit ? S_IDLE : S_MISS_REQ;
            S_MISS_REQ:    if (mem_req && mem_ack) state_n = S_REFILL_WAIT;
            S_REFILL_WAIT: if (mem_done) state_n = S_WRITE_TAG;
            S_WRITE_TAG:   state_n = S_IDLE;
            default:       state_n = S_INIT;
        endcase
    end

    // Datapath registers and registered handshake/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            line_q     <= '0;
            victim     <= 1'b0;
            lru        <= '0;
            mem_req    <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            req_ready  <= (state_n == S_IDLE);
            busy       <= (state_n != S_IDLE);
            mem_req    <= (state_n == S_MISS_REQ);
            resp_valid <= 1'b0;
            cnt        <= (state == S_INIT) ? cnt + IDX_W'(1) : '0;
            case (state)
                S_IDLE: begin
                    if (flush)
                        lru <= '0;
                    else if (req_valid)
                        line_q <= req_addr[ADDR_W-1:OFF_W];
                end
                S_LOOKUP: begin
                    if (hit) begin
                        resp_valid   <= 1'b1;
                        resp_hit     <= 1'b1;
                        resp_way     <= hit_way;
                        lru[set_q]   <= !hit_way;
                    end else begin
                        victim <= miss_victim;
                    end
                end
                S_REFILL_WAIT: begin
                    if (mem_done) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_way   <= victim;
                    end
                end
                S_WRITE_TAG:   lru[set_q] <= !victim;
                default: ;
            endcase
        end
    end

endmodule
